if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined processor.
- Owns the PC register and issues valid/ready requests to instruction memory.
- Handles branch redirect/flush and hazard stalls.
- Drives the IF/OF pipeline latch that feeds the operand-fetch stage: PC and instruction for immediate and branch-target calculation.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h6800_0000, encoding of nop (opcode 5'b01101) placed in the latch on flush/reset.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  fetch address (current PC).
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_resp_valid  input  1  instruction data valid.
- imem_resp_data  input  32  fetched instruction word.
- stall  input  1  hazard unit: hold IF/OF latch and PC.
- branch_taken  input  1  one-cycle redirect pulse from EX.
- branch_target  input  32  redirect PC.
- OF_valid  output  1  IF/OF latch holds a real instruction.
- OF_PC  output  32  PC of latched instruction.
- OF_instruction  output  32  latched instruction.

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC, state=IDLE, hold buffer empty.
  - OF_valid=0, OF_PC=0, OF_instruction=NOP_INSTR.
  - imem_req_valid=0, imem_req_addr=PC.
  - After release, IDLE goes to FETCH_REQ on the next edge.
- Combinational outputs: imem_req_valid=(state==FETCH_REQ); imem_req_addr=PC.
- States:
  - IDLE -> FETCH_REQ (unconditional).
  - FETCH_REQ: on imem_req_ready -> WAIT_RESP.
  - WAIT_RESP, on imem_resp_valid:
    - stall=0: latch <= {1, PC, data}, PC <= PC+4, -> FETCH_REQ.
    - stall=1: data into hold buffer, -> HOLD.
  - HOLD: when stall=0, latch <= {1, PC, hold}, PC <= PC+4, -> FETCH_REQ.
  - SQUASH: on imem_resp_valid, discard data, -> FETCH_REQ.
- Branch redirect (priority over stall and over any response in the same cycle):
  - Always: PC <= {branch_target[31:2], 2'b00}; OF_valid <= 0; OF_instruction <= NOP_INSTR; OF_PC <= 0.
  - In FETCH_REQ with imem_req_ready=1 (old PC accepted): -> SQUASH.
  - In FETCH_REQ with imem_req_ready=0: stay FETCH_REQ. Address changes to the new PC; the redirect is the only permitted change of an unaccepted request.
  - In WAIT_RESP with no response this cycle: -> SQUASH.
  - In WAIT_RESP with a response this cycle: discard it, -> FETCH_REQ.
  - In HOLD: discard the hold buffer, -> FETCH_REQ.
  - In SQUASH: stay in SQUASH, PC updated; a response in the same cycle is discarded and the state goes to FETCH_REQ.
- Stall (no branch):
  - OF_valid/OF_PC/OF_instruction and PC are held.
  - Requests may still be issued and accepted.
- Throughput and latency:
  - One outstanding request maximum.
  - Zero-wait memory: request accepted cycle N, response cycle N+1, OF outputs valid from cycle N+2.
  - Steady-state throughput: one instruction per 2 cycles.
- When no new instruction is loaded and there is no stall, OF_valid is cleared to 0; OF_PC and OF_instruction keep their last value.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- imem_resp_valid outside WAIT_RESP/SQUASH is ignored.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: RESET_PC=0, zero-wait memory returning 32'hA000_0000+addr.
  - Required: first request at 0 in the cycle after IDLE; OF_PC sequence 0,4,8 with matching instructions; OF_valid pulses every other cycle.
- Stall during response:
  - Stimulus: stall=1 for 3 cycles while the response for PC 8 arrives.
  - Required: latch holds the PC=4 entry; state HOLD; after release OF_PC=8 with correct data and no duplicate fetch.
- Branch while waiting:
  - Stimulus: branch_taken with target 32'h0000_0103 during WAIT_RESP for PC 12; memory responds 2 cycles later.
  - Required: that response is dropped; OF_instruction=32'h6800_0000 and OF_valid=0; next request addr=32'h0000_0100.
- Branch plus response same cycle:
  - Stimulus: branch to 32'h40 coincident with imem_resp_valid.
  - Required: data discarded; next imem_req_addr=32'h40; branch overrides a simultaneous stall.
- Backpressure and wrap:
  - Stimulus: imem_req_ready=0 for 5 cycles at PC 32'hFFFF_FFFC.
  - Required: imem_req_valid stays 1 with a stable address; after the fetch, next request addr=0.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously in WAIT_RESP.
  - Required: outputs immediately return to reset values; a stale imem_resp_valid is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, one-outstanding valid/ready instruction fetch, branch squash,
// stall hold buffer and the IF/OF pipeline latch.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h6800_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        OF_valid,
  output logic [31:0] OF_PC,
  output logic [31:0] OF_instruction
);
  typedef enum logic [2:0] {IDLE, FETCH_REQ, WAIT_RESP, HOLD, SQUASH} state_t;
  state_t      r_state;
  logic [31:0] r_pc, r_hold, r_of_pc, r_of_instr;
  logic        r_of_valid;
  logic        w_load;
  logic [31:0] w_instr;
  assign imem_req_valid = (r_state == FETCH_REQ);
  assign imem_req_addr  = r_pc;
  assign OF_valid       = r_of_valid;
  assign OF_PC          = r_of_pc;
  assign OF_instruction = r_of_instr;
  // A new instruction enters the latch either straight from memory or from the hold buffer.
  assign w_load  = !stall && ((r_state == WAIT_RESP && imem_resp_valid) || r_state == HOLD);
  assign w_instr = (r_state == HOLD) ? r_hold : imem_resp_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_hold     <= '0;
      r_of_valid <= 1'b0;
      r_of_pc    <= '0;
      r_of_instr <= NOP_INSTR;
    end else if (branch_taken) begin
      r_pc       <= branch_target & 32'hFFFF_FFFC;
      r_of_valid <= 1'b0;
      r_of_pc    <= '0;
      r_of_instr <= NOP_INSTR;
      case (r_state)
        FETCH_REQ:         r_state <= imem_req_ready ? SQUASH : FETCH_REQ;
        WAIT_RESP, SQUASH: r_state <= imem_resp_valid ? FETCH_REQ : SQUASH;
        default:           r_state <= FETCH_REQ;
      endcase
    end else if (w_load) begin
      r_of_valid <= 1'b1;
      r_of_pc    <= r_pc;
      r_of_instr <= w_instr;
      r_pc       <= r_pc + 32'd4;
      r_state    <= FETCH_REQ;
    end else begin
      if (!stall) r_of_valid <= 1'b0;
      case (r_state)
        IDLE:      r_state <= FETCH_REQ;
        FETCH_REQ: r_state <= imem_req_ready ? WAIT_RESP : FETCH_REQ;
        WAIT_RESP: begin
          if (imem_resp_valid) r_hold <= imem_resp_data;
          r_state <= imem_resp_valid ? HOLD : WAIT_RESP;
        end
        SQUASH:    r_state <= imem_resp_valid ? FETCH_REQ : SQUASH;
        default:   r_state <= r_state;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed vector table plus hand sequences for squash, backpressure/wrap
// and asynchronous reset; memory model returns 32'hA000_0000 + address one cycle after accept.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h6800_0000;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        OF_valid;
  logic [31:0] OF_PC, OF_instruction;
  int errs = 0, checks = 0, accepts = 0;
  logic auto_mem = 1'b1;

  if_fetch_stage dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .OF_valid(OF_valid), .OF_PC(OF_PC), .OF_instruction(OF_instruction)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] addr;
    logic        ofv;
    logic [31:0] ofpc;
    logic [31:0] ins;
  } vec_t;
  vec_t vecs [11];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk(input string tag, input logic rv, input logic [31:0] addr, input logic ofv,
                     input logic [31:0] ofpc, input logic [31:0] ins);
    cmp({tag, " req_valid"}, {31'd0, imem_req_valid}, {31'd0, rv});
    cmp({tag, " req_addr"}, imem_req_addr, addr);
    cmp({tag, " OF_valid"}, {31'd0, OF_valid}, {31'd0, ofv});
    cmp({tag, " OF_PC"}, OF_PC, ofpc);
    cmp({tag, " OF_instruction"}, OF_instruction, ins);
  endtask

  task automatic tick();
    logic acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    if (acc) accepts++;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_resp_valid = acc;
      imem_resp_data  = 32'hA000_0000 + a;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0, NOP};
    vecs[1]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0, NOP};
    vecs[2]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd0, 32'hA000_0000};
    vecs[3]  = '{1'b0, 1'b0, 32'd4,  1'b0, 32'd0, 32'hA000_0000};
    vecs[4]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd4, 32'hA000_0004};
    vecs[5]  = '{1'b0, 1'b0, 32'd8,  1'b0, 32'd4, 32'hA000_0004};
    vecs[6]  = '{1'b1, 1'b0, 32'd8,  1'b0, 32'd4, 32'hA000_0004};
    vecs[7]  = '{1'b1, 1'b0, 32'd8,  1'b0, 32'd4, 32'hA000_0004};
    vecs[8]  = '{1'b1, 1'b0, 32'd8,  1'b0, 32'd4, 32'hA000_0004};
    vecs[9]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd8, 32'hA000_0008};
    vecs[10] = '{1'b0, 1'b0, 32'd12, 1'b0, 32'd8, 32'hA000_0008};
    #12;
    chk("reset", 1'b0, 32'd0, 1'b0, 32'd0, NOP);
    #8 reset = 1'b0;
    #1;
    chk("idle", 1'b0, 32'd0, 1'b0, 32'd0, NOP);
    // Sequential fetch, then a 3-cycle stall as the PC=8 response arrives.
    foreach (vecs[i]) begin
      stall = vecs[i].st;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].rv, vecs[i].addr, vecs[i].ofv, vecs[i].ofpc, vecs[i].ins);
    end
    cmp("accept count", accepts, 32'd4);
    // Branch while waiting for PC 12; late response must be dropped.
    auto_mem = 1'b0;
    imem_resp_valid = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0103;
    tick();
    branch_taken = 1'b0;
    chk("br_wait", 1'b0, 32'h100, 1'b0, 32'd0, NOP);
    tick();
    chk("squash1", 1'b0, 32'h100, 1'b0, 32'd0, NOP);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    chk("squash_drop", 1'b1, 32'h100, 1'b0, 32'd0, NOP);
    // Branch coincident with response and stall.
    auto_mem = 1'b1;
    tick();
    chk("req100", 1'b0, 32'h100, 1'b0, 32'd0, NOP);
    branch_taken = 1'b1;
    branch_target = 32'h40;
    stall = 1'b1;
    tick();
    branch_taken = 1'b0;
    stall = 1'b0;
    chk("br_resp", 1'b1, 32'h40, 1'b0, 32'd0, NOP);
    tick();
    tick();
    chk("fetch40", 1'b1, 32'h44, 1'b1, 32'h40, 32'hA000_0040);
    // Redirect an unaccepted request to the top of memory, then backpressure and wrap.
    imem_req_ready = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    chk("br_fetch", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, NOP);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp%0d", k), 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, NOP);
    end
    imem_req_ready = 1'b1;
    tick();
    tick();
    chk("wrap", 1'b1, 32'd0, 1'b1, 32'hFFFF_FFFC, 32'h9FFF_FFFC);
    tick();
    tick();
    chk("post_wrap", 1'b1, 32'd4, 1'b1, 32'd0, 32'hA000_0000);
    // Asynchronous reset while waiting for the PC=4 response.
    tick();
    auto_mem = 1'b0;
    imem_resp_valid = 1'b0;
    chk("pre_rst", 1'b0, 32'd4, 1'b0, 32'd0, 32'hA000_0000);
    #2 reset = 1'b1;
    #1;
    chk("async_rst", 1'b0, 32'd0, 1'b0, 32'd0, NOP);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h1234_5678;
    #3 reset = 1'b0;
    tick();
    imem_resp_valid = 1'b0;
    chk("rst_idle", 1'b1, 32'd0, 1'b0, 32'd0, NOP);
    auto_mem = 1'b1;
    tick();
    tick();
    chk("restart", 1'b1, 32'd4, 1'b1, 32'd0, 32'hA000_0000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
